// File: rtl/emsg_pkg.sv
// Shared sizing for the compressed check-message expander: defaults, derived
// widths and bit offsets of the {min1, min2, pos, sign} word.
package emsg_pkg;
  localparam int W_DEF  = 6;
  localparam int WC_DEF = 32;
  localparam int P_DEF  = 4;

  function automatic int ecomp_w(input int w, input int wc);
    return 3 * (w - 1) + wc;
  endfunction

  // Beat index width; a single-beat word still gets a 1-bit counter.
  function automatic int beat_w(input int wc, input int p);
    return (wc / p > 1) ? $clog2(wc / p) : 1;
  endfunction

  function automatic int sign_lo();
    return 0;
  endfunction

  function automatic int pos_lo(input int wc);
    return wc;
  endfunction

  function automatic int min2_lo(input int w, input int wc);
    return wc + (w - 1);
  endfunction

  function automatic int min1_lo(input int w, input int wc);
    return wc + 2 * (w - 1);
  endfunction

  localparam int ECOMP_W_DEF = ecomp_w(W_DEF, WC_DEF);
  localparam int BEAT_W_DEF  = beat_w(WC_DEF, P_DEF);
endpackage

// File: rtl/emsg_fifo2.sv
// Two-entry in-order word buffer; push is ignored when full, pop when empty.
module emsg_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  logic [1:0][DW-1:0] mem_q;
  logic               wr_q, rd_q;
  logic [1:0]         cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/emsg_expand.sv
// Expands a compressed min-sum check message into WC signed edge messages,
// P edges per beat, behind a 2-entry input buffer and a registered output.
module emsg_expand
  import emsg_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int WC     = WC_DEF,
  parameter int P      = P_DEF,
  parameter int OFFSET = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ecomp_w(W,WC)-1:0]  in_ecomp,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [P*W-1:0]            out_msg,
  output logic [beat_w(WC,P)-1:0]   out_beat,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int MW = W - 1;
  localparam int NB = WC / P;
  localparam int BW = beat_w(WC, P);
  localparam int EW = ecomp_w(W, WC);
  localparam logic [MW-1:0] OFF = MW'(OFFSET);

  logic          full, empty, push, pop, load, last_beat, init_q;
  logic [EW-1:0] head;
  logic [MW-1:0] min1, min2, pos;
  logic [WC-1:0] sgn;
  logic [BW-1:0] beat_q, beat_d, out_beat_q;
  logic [P-1:0][W-1:0] lane_msg, out_msg_q;
  logic          out_valid_q, out_last_q;

  // init_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = init_q & ~full;
  assign push      = in_valid & in_ready;
  assign load      = ~empty & (~out_valid_q | out_ready);
  assign last_beat = (beat_q == BW'(NB - 1));
  assign pop       = load & last_beat;
  assign beat_d    = last_beat ? '0 : beat_q + BW'(1);

  emsg_fifo2 #(.DW(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_ecomp),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign min1 = head[min1_lo(W, WC) +: MW];
  assign min2 = head[min2_lo(W, WC) +: MW];
  assign pos  = head[pos_lo(WC) +: MW];
  assign sgn  = head[sign_lo() +: WC];

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic [MW-1:0] e, mag, cmag;
    logic [W-1:0]  ext;
    assign e    = MW'(beat_q) * MW'(P) + MW'(l);
    assign mag  = (e == pos) ? min2 : min1;
    assign cmag = (mag > OFF) ? mag - OFF : '0;
    assign ext  = {1'b0, cmag};
    // Negating a zero magnitude wraps back to all-zeros, so no -0 code appears.
    assign lane_msg[l] = sgn[e] ? ('0 - ext) : ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q      <= 1'b0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_beat_q  <= '0;
      out_msg_q   <= '0;
    end else begin
      init_q <= 1'b1;
      if (load) begin
        out_msg_q   <= lane_msg;
        out_beat_q  <= beat_q;
        out_last_q  <= last_beat;
        out_valid_q <= 1'b1;
        beat_q      <= beat_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_msg   = out_msg_q;
  assign out_beat  = out_beat_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_emsg_expand.sv
// Scoreboard bench for emsg_expand: OFFSET=0 and OFFSET=1 instances share stimulus.
module tb_emsg_expand;
  typedef struct {
    logic [23:0] msg;
    logic [2:0]  beat;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [46:0] in_ecomp;
  logic        in_valid;
  logic        out_ready;
  logic        rdy_force, rand_rdy, rnd_rdy;
  logic        ir[2];
  logic [23:0] omsg[2];
  logic [2:0]  obeat[2];
  logic        olast[2];
  logic        ov[2];

  exp_t        sbq[2][$];
  int          total = 0, bad = 0;
  int          ncyc = 0, t_b0 = 0, t_last = 0, run = 0, last_run = 0;
  logic        stalled[2];
  logic [23:0] pmsg[2];
  logic [2:0]  pbeat[2];
  logic        plast[2];

  always #5 clk = ~clk;

  assign out_ready = rand_rdy ? rnd_rdy : rdy_force;

  emsg_expand #(.W(6), .WC(32), .P(4), .OFFSET(0)) dut0 (
    .clk(clk), .rst(rst), .in_ecomp(in_ecomp), .in_valid(in_valid), .in_ready(ir[0]),
    .out_msg(omsg[0]), .out_beat(obeat[0]), .out_last(olast[0]), .out_valid(ov[0]),
    .out_ready(out_ready));

  emsg_expand #(.W(6), .WC(32), .P(4), .OFFSET(1)) dut1 (
    .clk(clk), .rst(rst), .in_ecomp(in_ecomp), .in_valid(in_valid), .in_ready(ir[1]),
    .out_msg(omsg[1]), .out_beat(obeat[1]), .out_last(olast[1]), .out_valid(ov[1]),
    .out_ready(out_ready));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one signed edge value straight from the min-sum expansion rule.
  function automatic logic [5:0] edge_val(input int e, input int m1, input int m2,
                                          input int pos, input logic [31:0] sg, input int off);
    int mag, c, v;
    logic [5:0] r;
    mag = (e == pos) ? m2 : m1;
    c   = (mag > off) ? mag - off : 0;
    v   = sg[e] ? -c : c;
    r   = v[5:0];
    return r;
  endfunction

  function automatic logic [46:0] mk(input int m1, input int m2, input int pos, input logic [31:0] s);
    logic [4:0] a, b, c;
    a = m1[4:0]; b = m2[4:0]; c = pos[4:0];
    return {a, b, c, s};
  endfunction

  task automatic push_word(input logic [46:0] w);
    exp_t x;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 8; b++) begin
        x.msg = '0;
        for (int l = 0; l < 4; l++)
          x.msg[l*6 +: 6] = edge_val(b*4 + l, int'(w[46:42]), int'(w[41:37]),
                                     int'(w[36:32]), w[31:0], d);
        x.beat = 3'(b);
        x.last = (b == 7);
        sbq[d].push_back(x);
      end
  endtask

  always begin
    @(posedge clk); #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples mid-cycle, away from every stimulus change.
  always begin
    exp_t x;
    @(negedge clk); #2;
    ncyc++;
    if (!rst) begin
      sbq[0].delete();
      sbq[1].delete();
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
      run = 0;
    end else begin
      if (in_valid && ir[0]) push_word(in_ecomp);
      for (int d = 0; d < 2; d++) begin
        if (stalled[d]) begin
          chk("hold_valid", ov[d], 1'b1);
          chk("hold_msg", omsg[d], pmsg[d]);
          chk("hold_beat", obeat[d], pbeat[d]);
          chk("hold_last", olast[d], plast[d]);
        end
        if (ov[d] && out_ready) begin
          if (sbq[d].size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
          else begin
            x = sbq[d].pop_front();
            chk($sformatf("msg%0d", d), omsg[d], x.msg);
            chk($sformatf("beat%0d", d), obeat[d], x.beat);
            chk($sformatf("last%0d", d), olast[d], x.last);
            if (d == 0 && x.beat == 0) t_b0 = ncyc;
            if (d == 0 && x.last) begin
              t_last   = ncyc;
              last_run = run + 1;
            end
          end
        end
        stalled[d] = ov[d] && !out_ready;
        pmsg[d]  = omsg[d];
        pbeat[d] = obeat[d];
        plast[d] = olast[d];
      end
      run = (ov[0] && out_ready) ? run + 1 : 0;
    end
  end

  task automatic send(input logic [46:0] w);
    int n;
    n = 0;
    in_ecomp = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ir[0] || n >= 200) break;
      n++;
    end
    chk("accept_timeout", n < 200, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0 || ov[0] || ov[1]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 500, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_beat(input logic [2:0] b);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if ((ov[0] && obeat[0] == b) || n >= 100) break;
      n++;
    end
    chk("wait_beat_timeout", n < 100, 1'b1);
  endtask

  initial begin
    logic [46:0] wa;
    rst = 1'b0; in_valid = 1'b0; in_ecomp = '0;
    rdy_force = 1'b1; rand_rdy = 1'b0;
    wa = mk(3, 7, 5, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_valid", ov[0], 1'b0);
    chk("rst_ready", ir[0], 1'b0);
    chk("rst_msg", omsg[0], 24'h0);
    chk("rst_beat", obeat[0], 3'd0);
    chk("rst_last", olast[0], 1'b0);
    rst = 1'b1;
    #1 chk("ready_before_edge", ir[0], 1'b0);
    @(posedge clk); #1;
    chk("ready_after_edge", ir[0], 1'b1);

    // Directed words: min2 at pos, single and full negative signs, offset floor.
    send(wa); drain();
    send(mk(3, 7, 5, 32'h0000_0001)); drain();
    send(mk(3, 7, 5, 32'hFFFF_FFFF)); drain();
    send(mk(0, 1, 9, 32'hFFFF_FFFF)); drain();
    send(mk(31, 0, 31, 32'h8000_0000)); drain();

    // Downstream stall of 3 cycles at beat 2.
    send(wa);
    wait_beat(3'd2);
    rdy_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy_force = 1'b1;
    drain();
    chk("stall_span", t_last - t_b0 + 1, 11);

    // Three back-to-back words.
    send(mk(1, 2, 0, 32'h1234_5678));
    send(mk(4, 9, 31, 32'hA5A5_5A5A));
    chk("ready_drop", ir[0], 1'b0);
    send(mk(15, 20, 16, 32'h0F0F_F0F0));
    drain();
    chk("b2b_run", last_run, 24);

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 send(mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom));
    end
    rand_rdy = 1'b0;
    drain();

    // Reset mid-word at beat 3.
    send(wa);
    wait_beat(3'd3);
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", ov[0], 1'b0);
    chk("arst_valid1", ov[1], 1'b0);
    chk("arst_beat", obeat[0], 3'd0);
    chk("arst_msg", omsg[0], 24'h0);
    chk("arst_ready", ir[0], 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rel_ready_low", ir[0], 1'b0);
    @(posedge clk); #1;
    chk("rel_ready_high", ir[0], 1'b1);
    send(mk(6, 2, 12, 32'hC3C3_0001));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/emsg_expand.md
EMSG_EXPAND -- requirements
Module: emsg_expand

Interface
REQ-001 SHALL have parameter W, default 6: channel message width, two's complement.
REQ-002 SHALL have parameter WC, default 32: check-node degree, with WC <= 2^(W-1).
REQ-003 SHALL have parameter P, default 4: edges output per beat, with WC % P == 0.
REQ-004 SHALL have parameter OFFSET, default 0: offset min-sum correction subtracted from each magnitude.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port in_ecomp, input, 3*(W-1)+WC bits: compressed check message packed as {min1, min2, pos, sign[WC-1:0]} MSB to LSB (47 bits by default).
REQ-008 SHALL have port in_valid, input, 1 bit: in_ecomp is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-010 SHALL have port out_msg, output, P*W bits: lane l at bits [(l+1)*W-1 : l*W] carries edge beat*P+l.
REQ-011 SHALL have port out_beat, output, clog2(WC/P) bits: beat index within the current word.
REQ-012 SHALL have port out_last, output, 1 bit: this is the final beat of the word.
REQ-013 SHALL have port out_valid, output, 1 bit: out_msg, out_beat and out_last are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.

Function
REQ-015 SHALL transfer a word on any rising edge where in_valid and in_ready are both 1. Each transfer writes one entry of a 2-entry FIFO.
REQ-016 SHALL drive in_ready = 1 exactly when the FIFO holds fewer than 2 entries. in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL compute each edge e as follows:
- mag = (e == pos) ? min2 : min1;
- cmag = mag > OFFSET ? mag - OFFSET : 0;
- msg = sign[e] ? -cmag : cmag, in W bits. This never overflows; a negated zero yields 0.
REQ-018 SHALL register the output stage. It loads the next beat on an edge where the FIFO is non-empty and (out_valid == 0 or out_ready == 1).
REQ-019 SHALL make beat 0 of a word accepted on edge k visible after edge k+1 when the output stage is idle or draining. The FIFO bypass is not registered twice.
REQ-020 SHALL step beats 0..WC/P-1 in order with no gaps while out_ready stays 1. out_last = 1 on beat WC/P-1. The FIFO head pops when that last beat is loaded.
REQ-021 SHALL start beat 0 of the next word on the cycle after the last beat of the previous word, for back-to-back words (sustained 1 beat per cycle).
REQ-022 SHALL hold out_msg, out_beat and out_last stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL, on a simultaneous push and pop, update the FIFO count by net zero and keep word order.
REQ-024 SHALL reset the beat counter to 0 on each new word (wrap-around).

Reset
REQ-025 SHALL, while rst = 0, asynchronously force out_valid = 0, out_last = 0, out_beat = 0, out_msg = 0, FIFO empty and beat counter = 0.
REQ-026 SHALL drive in_ready = 0 while rst = 0 and in_ready = 1 from the first edge after release.
REQ-027 SHALL discard a word in progress when reset is asserted mid-operation; no partial beats resume after release.

Structure
REQ-028 SHALL place in a shared package:
- W, WC and P defaults;
- derived widths (ecomp width, beat width);
- field offsets for min1, min2, pos and sign.
REQ-029 SHALL implement the 2-entry buffer as sub-module emsg_fifo2, with push/pop/full/empty ports and the same clock and reset.
REQ-030 SHALL keep the per-edge magnitude/sign/offset logic as a P-lane generate loop in emsg_expand.

Verification
REQ-031 SHALL check min1=3, min2=7, pos=5, sign=0, out_ready=1 -> beat 1 is lanes {3,7,3,3} (lane1 = edge5 = 7), and every other edge is 3.
REQ-032 SHALL check the same word with sign=0x00000001 -> beat 0 lane0 = 6'h3D (-3). With sign=0xFFFFFFFF, every edge is negative.
REQ-033 SHALL check out_ready held 0 for 3 cycles at beat 2 -> out_msg, out_beat=2 and out_valid are held. The word completes in 8 + 3 cycles.
REQ-034 SHALL check three words offered back-to-back with out_ready=1:
- in_ready drops after 2 are buffered;
- out_valid stays 1 for 24 consecutive beats;
- out_last pulses on beats 7, 15 and 23.
REQ-035 SHALL check OFFSET=1 with min1=0, min2=1, sign=all ones -> all edges 0. No -0 pattern other than 6'h00 appears.
REQ-036 SHALL check rst driven to 0 at beat 3 -> out_valid falls without waiting for a clock edge. After release, the next accepted word starts at beat 0 with no stale data.
